// File: rtl/sw_input_pkg.sv
// Shared constants for the slide-switch input controller.
// Register addresses and ctrl bit positions used by RTL and bench.
package sw_input_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_MASK = 2'd1,
        ADDR_EDGE = 2'd2,
        ADDR_CTRL = 2'd3
    } addr_e;

    localparam int CTRL_RISE   = 0;
    localparam int CTRL_FALL   = 1;
    localparam int CTRL_BYPASS = 2;

    localparam logic [2:0] CTRL_RESET = 3'b011;

endpackage

// File: rtl/sw_input_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch input controller.
// The CPU data master drives the master side, the controller the slave side.
interface sw_input_ctrl_if;

    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, debounce counter, stable level.
// stable_nxt_o exposes the next stable value so edges land on the update edge.
module sw_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    input  logic bypass_i,
    output logic stable_o,
    output logic stable_nxt_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any return to the stable level clears the count
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (bypass_i) begin
            stable_d = sync2_q;
        end else if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o     = stable_q;
    assign stable_nxt_o = stable_d;

endmodule

// File: rtl/sw_input_ctrl.sv
// Avalon-MM switch input port: debounced data, sticky edge capture,
// interrupt mask and control registers with a registered irq.
module sw_input_ctrl
    import sw_input_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    sw_input_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [2:0]       ctrl_q;
    logic [2:0]       ctrl_d;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             irq_q;
    logic             irq_d;
    addr_e            addr;
    logic             unused_wdata;

    assign addr         = addr_e'(bus.address);
    assign unused_wdata = ^bus.writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .din_i       (in_port[i]),
            .bypass_i    (ctrl_q[CTRL_BYPASS]),
            .stable_o    (stable[i]),
            .stable_nxt_o(stable_nxt[i])
        );
    end

    assign rise = stable_nxt & ~stable;
    assign fall = ~stable_nxt & stable;

    always_comb begin
        mask_d = mask_q;
        ctrl_d = ctrl_q;
        w1c    = '0;
        if (bus.write) begin
            unique case (addr)
                ADDR_DATA: ;
                ADDR_MASK: mask_d = bus.writedata[WIDTH-1:0];
                ADDR_EDGE: w1c    = bus.writedata[WIDTH-1:0];
                ADDR_CTRL: ctrl_d = bus.writedata[2:0];
            endcase
        end
    end

    // A new edge overrides a same-cycle clear of that bit
    assign edge_d = (edge_q & ~w1c)
                  | (rise & {WIDTH{ctrl_q[CTRL_RISE]}})
                  | (fall & {WIDTH{ctrl_q[CTRL_FALL]}});

    assign irq_d = |(edge_q & mask_q);

    always_comb begin
        rdata_d = rdata_q;
        if (bus.read) begin
            unique case (addr)
                ADDR_DATA: rdata_d = 32'(stable);
                ADDR_MASK: rdata_d = 32'(mask_q);
                ADDR_EDGE: rdata_d = 32'(edge_q);
                ADDR_CTRL: rdata_d = 32'(ctrl_q);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q  <= '0;
            edge_q  <= '0;
            ctrl_q  <= CTRL_RESET;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Directed bench for sw_input_ctrl with a short debounce window.
// Register vectors from a table, multi-cycle corners as sequences.
module tb_sw_input_ctrl;
    import sw_input_pkg::*;

    localparam int WIDTH = 10;
    localparam int DB    = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_port = '0;
    logic             irq;
    int               tests = 0;
    int               fails = 0;

    sw_input_ctrl_if bus();

    sw_input_ctrl #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] rd;
    int          bad;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        tick(1);
        bus.write     = 1'b0;
    endtask

    task automatic avm_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        tick(1);
        bus.read    = 1'b0;
        d           = bus.readdata;
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd0, 32'h0,        32'h000, "rst_data"};
        vecs[1] = '{1'b0, 2'd1, 32'h0,        32'h000, "rst_mask"};
        vecs[2] = '{1'b0, 2'd2, 32'h0,        32'h000, "rst_edge"};
        vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h003, "rst_ctrl"};
        vecs[4] = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h3FF, "mask_rw"};
        vecs[5] = '{1'b1, 2'd1, 32'h0,        32'h000, "mask_clr"};
        vecs[6] = '{1'b1, 2'd3, 32'hFFFFFFF8, 32'h000, "ctrl_rw0"};
        vecs[7] = '{1'b1, 2'd3, 32'h3,        32'h003, "ctrl_rw3"};
        vecs[8] = '{1'b1, 2'd0, 32'h155,      32'h000, "data_ro"};
        vecs[9] = '{1'b1, 2'd2, 32'h3FF,      32'h000, "edge_w1c_empty"};

        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        tick(3);
        reset = 1'b0;
        check("rst_irq", 32'(irq), 32'h0);

        // 1: reset values and register read/write
        foreach (vecs[i]) begin
            if (vecs[i].wr) avm_write(vecs[i].addr, vecs[i].wdata);
            avm_read(vecs[i].addr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end
        check("tbl_irq", 32'(irq), 32'h0);

        // 2: clean rise on bit 3, debounce latency, mask -> irq
        in_port     = 10'h008;
        bus.address = ADDR_DATA;
        bus.read    = 1'b1;
        tick(10);
        check("t2_data_early", bus.readdata, 32'h0);
        tick(1);
        check("t2_data_k9", bus.readdata, 32'h8);
        bus.read = 1'b0;
        avm_read(ADDR_EDGE, rd);
        check("t2_edge", rd, 32'h8);
        check("t2_irq_masked", 32'(irq), 32'h0);
        avm_write(ADDR_MASK, 32'h8);
        check("t2_irq_lag", 32'(irq), 32'h0);
        tick(1);
        check("t2_irq_set", 32'(irq), 32'h1);

        // 3: drop bit 3, clear, then a bouncing bit 0
        in_port = 10'h000;
        tick(12);
        avm_read(ADDR_EDGE, rd);
        check("t3_fall_b3", rd, 32'h8);
        avm_write(ADDR_EDGE, 32'h3FF);
        check("t3_irq_hold", 32'(irq), 32'h1);
        tick(1);
        check("t3_irq_clr", 32'(irq), 32'h0);
        bus.address = ADDR_EDGE;
        bus.read    = 1'b1;
        bad         = 0;
        for (int i = 0; i < 13; i++) begin
            in_port[0] = ~in_port[0];
            if (i < 12) begin
                for (int j = 0; j < 3; j++) begin
                    tick(1);
                    if (bus.readdata != 32'h0) bad++;
                end
            end
        end
        check("t3_bounce_quiet", 32'(bad), 32'h0);
        tick(10);
        check("t3_no_early", bus.readdata, 32'h0);
        tick(1);
        check("t3_edge_b0", bus.readdata, 32'h1);
        bus.read = 1'b0;
        avm_read(ADDR_DATA, rd);
        check("t3_data", rd, 32'h1);

        // 4: W1C, and set beating a same-cycle clear
        in_port = 10'h009;
        tick(12);
        avm_read(ADDR_EDGE, rd);
        check("t4_edge9", rd, 32'h9);
        avm_write(ADDR_EDGE, 32'h1);
        avm_read(ADDR_EDGE, rd);
        check("t4_w1c", rd, 32'h8);
        in_port = 10'h008;
        tick(12);
        avm_write(ADDR_EDGE, 32'h1);
        avm_read(ADDR_EDGE, rd);
        check("t4_w1c_fall", rd, 32'h8);
        in_port = 10'h009;
        tick(9);
        avm_write(ADDR_EDGE, 32'h1);
        avm_read(ADDR_EDGE, rd);
        check("t4_set_wins", rd, 32'h9);

        // 5: simultaneous read/write, then bypass with fall-only capture
        avm_write(ADDR_EDGE, 32'h3FF);
        bus.address   = ADDR_CTRL;
        bus.writedata = 32'h6;
        bus.write     = 1'b1;
        bus.read      = 1'b1;
        tick(1);
        bus.write = 1'b0;
        bus.read  = 1'b0;
        check("t5_rw_prewrite", bus.readdata, 32'h3);
        avm_read(ADDR_CTRL, rd);
        check("t5_ctrl", rd, 32'h6);
        in_port = 10'h3FF;
        tick(4);
        avm_read(ADDR_EDGE, rd);
        check("t5_rise_none", rd, 32'h0);
        in_port     = 10'h1FF;
        bus.address = ADDR_DATA;
        bus.read    = 1'b1;
        tick(3);
        check("t5_bypass_early", bus.readdata, 32'h3FF);
        tick(1);
        check("t5_bypass_k2", bus.readdata, 32'h1FF);
        bus.read = 1'b0;
        avm_read(ADDR_EDGE, rd);
        check("t5_fall_b9", rd, 32'h200);

        // 6: reset in the middle of a debounce
        avm_write(ADDR_CTRL, 32'h3);
        avm_write(ADDR_MASK, 32'h3FF);
        tick(1);
        check("t6_irq_pre", 32'(irq), 32'h1);
        in_port = 10'h005;
        tick(4);
        reset = 1'b1;
        #1;
        check("t6_irq_async", 32'(irq), 32'h0);
        check("t6_rdata_async", bus.readdata, 32'h0);
        tick(2);
        reset       = 1'b0;
        bus.address = ADDR_DATA;
        bus.read    = 1'b1;
        tick(10);
        check("t6_data_early", bus.readdata, 32'h0);
        tick(1);
        check("t6_data", bus.readdata, 32'h5);
        bus.read = 1'b0;
        avm_read(ADDR_EDGE, rd);
        check("t6_edge", rd, 32'h5);
        avm_read(ADDR_MASK, rd);
        check("t6_mask", rd, 32'h0);
        avm_read(ADDR_CTRL, rd);
        check("t6_ctrl", rd, 32'h3);
        check("t6_irq", 32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
